// File: rtl/cpu_pkg.sv
// Shared CPU constants and the machine-word type used by the register file.
package cpu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

    typedef logic [XLEN_DEFAULT-1:0] word_t;

endpackage

// File: rtl/sb_bits.sv
// Scoreboard busy vector: one pending bit per register, issue-set wins over write-clear.
module sb_bits
    import cpu_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr0_en,
    input  logic [AW-1:0]   clr0_idx,
    input  logic            clr1_en,
    input  logic [AW-1:0]   clr1_idx,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                // Register 0 is hardwired, so it can never be pending.
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_reg
                logic w_set;
                logic w_clr;
                assign w_set = set_en && (set_idx == AW'(gi));
                assign w_clr = (clr0_en && (clr0_idx == AW'(gi))) ||
                               (clr1_en && (clr1_idx == AW'(gi)));
                assign w_busy_next[gi] = w_set || (r_busy[gi] && !w_clr);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through read bypass and an issue scoreboard.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  logic [XLEN-1:0]   wdata0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  logic [XLEN-1:0]   wdata1,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic [NREG-1:0]   busy_vec
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] w_busy;

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            if (we0 && (waddr0 != '0)) begin
                r_regs[waddr0] <= wdata0;
            end
            if (we1 && (waddr1 != '0)) begin
                r_regs[waddr1] <= wdata1;
            end
        end
    end

    sb_bits #(
        .NREG (NREG)
    ) u_sb_bits (
        .clk      (clk),
        .reset    (reset),
        .set_en   (iss_valid),
        .set_idx  (iss_rd),
        .clr0_en  (we0),
        .clr0_idx (waddr0),
        .clr1_en  (we1),
        .clr1_idx (waddr1),
        .busy     (w_busy)
    );

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic          w_hit0;
            logic          w_hit1;

            assign w_ra   = raddr[gi*AW +: AW];
            assign w_hit0 = we0 && (waddr0 == w_ra);
            assign w_hit1 = we1 && (waddr1 == w_ra);

            // Bypass stays live under reset; only storage and busy state are reset.
            assign rdata[gi*XLEN +: XLEN] = (w_ra == '0) ? '0     :
                                            w_hit1       ? wdata1 :
                                            w_hit0       ? wdata0 :
                                                           r_regs[w_ra];

            assign rbusy[gi] = (w_ra != '0) && w_busy[w_ra] && !(w_hit0 || w_hit1);
        end
    endgenerate

    assign busy_vec = w_busy;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, at least 2.
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1..4.
REQ-004 SHALL have derived localparam AW = $clog2(NREG).
REQ-005 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port raddr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW].
REQ-008 SHALL have port rdata  out  NRD*XLEN  read data, per-port slices as for raddr.
REQ-009 SHALL have port rbusy  out  NRD  per-port hazard flag.
REQ-010 SHALL have port we0  in  1  write port 0 enable.
REQ-011 SHALL have port waddr0  in  AW  write port 0 address.
REQ-012 SHALL have port wdata0  in  XLEN  write port 0 data.
REQ-013 SHALL have ports we1/waddr1/wdata1, same widths, for write port 1.
REQ-014 SHALL have port iss_valid  in  1  issue strobe; marks destination pending.
REQ-015 SHALL have port iss_rd  in  AW  destination register of the issued instruction.
REQ-016 SHALL have port busy_vec  out  NREG  current scoreboard bits.

Function
REQ-017 SHALL make register 0 read as zero at all times; writes to it are dropped and its busy bit is never set.
REQ-018 SHALL update storage on the rising clk edge when weN=1 and waddrN!=0.
REQ-019 SHALL give port 1 priority when we0 and we1 target the same address; only wdata1 is stored.
REQ-020 SHALL make reads combinational (zero latency) with write-through bypass: a read of an address being written this cycle returns the incoming data, with port 1 taking priority over port 0.
REQ-021 SHALL set busy[iss_rd] on the edge when iss_valid=1 and iss_rd!=0.
REQ-022 SHALL clear busy[a] on the edge when either write port writes address a.
REQ-023 SHALL give set priority over clear on the same edge for the same register, so the register stays busy.
REQ-024 SHALL compute rbusy[i] = busy[raddr_i] AND NOT (same-cycle write to raddr_i); rbusy[i]=0 whenever raddr_i=0.
REQ-025 SHALL make busy_vec reflect registered state only, with no same-cycle bypass.
REQ-026 SHALL accept an unbusy write (a write to a non-busy register) as a normal write with no error.

Reset
REQ-027 SHALL clear all registers to 0 and all busy bits to 0 on the first edge with reset=1.
REQ-028 SHALL ignore we0, we1 and iss_valid during any cycle with reset=1; reset asserted mid-operation discards all pending state.
REQ-029 SHALL keep the zero-read of register 0 and the rdata bypass of REQ-020 combinational under reset; rbusy SHALL be 0 in the cycle after reset.

Structure
REQ-030 SHALL place the default XLEN and NREG constants and the width type (logic [XLEN-1:0]) in a shared package, cpu_pkg.
REQ-031 SHALL implement the scoreboard as sub-module sb_bits (busy vector with set/clear priority); storage and bypass stay in regfile_sb.
REQ-032 SHALL use no vendor RAM macros; storage is a flop array.

Verification
REQ-033 SHALL cover: reset, then we0=1, waddr0=5, wdata0=0xDEADBEEF; next cycle raddr0=5 -> rdata0=0xDEADBEEF.
REQ-034 SHALL cover: we0=1 and we1=1, both at address 7, with data 0x11 and 0x22 -> same-cycle read returns 0x22, next-cycle read returns 0x22.
REQ-035 SHALL cover: we1=1, waddr1=0, wdata1=0xFFFFFFFF -> a read of register 0 returns 0 in the same and the following cycle.
REQ-036 SHALL cover: iss_valid=1, iss_rd=9 -> next cycle busy_vec[9]=1 and rbusy0=1 with raddr0=9; then we0 writes register 9 with 0x5 -> rbusy0=0 and rdata0=0x5 in that cycle, busy_vec[9]=0 after the edge.
REQ-037 SHALL cover: iss_valid=1, iss_rd=3 on the same edge as we0 writing register 3 -> busy_vec[3]=1 after the edge.
REQ-038 SHALL cover: registers 4 and 6 written, register 8 issued, then reset=1 for one cycle -> all reads return 0 and busy_vec=0.
